optical_flow_pyramidal_top: RTL and testbench



---
 rtl/optical_flow_pyramidal_top.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_optical_flow_pyramidal_top.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/optical_flow_pyramidal_top.sv
// optical_flow_pyramidal_top: streaming two-level 2x2 box pyramid with a coarse normal-flow estimate per L2 pixel.
// Optional macro OF_PYR_SATURATE_EN clamps flow_u/flow_v to [-127, +127]; undefined gives the raw 9-bit result.

module optical_flow_pyramidal_fsm #(
    parameter int unsigned TOTAL_BEATS = 76800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_valid,
    output logic o_busy,
    output logic o_done,
    output logic o_start_go,
    output logic o_accept
);
    localparam int unsigned CW = $clog2(TOTAL_BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUILD   = 2'd1,
        FLUSH   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] r_beat_cnt;
    logic [1:0]    r_flush_cnt;

    assign o_start_go = i_start && ((state == IDLE) || (state == DONE_ST));
    assign o_accept   = i_valid && (state == BUILD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE_ST: begin
                    if (i_start) begin
                        state      <= BUILD;
                        r_beat_cnt <= '0;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                    end
                end
                BUILD: begin
                    if (i_valid) begin
                        if (r_beat_cnt == CW'(TOTAL_BEATS - 1)) begin
                            state       <= FLUSH;
                            r_flush_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Four cycles let the three-stage pyramid pipeline drain before DONE_ST.
                    if (r_flush_cnt == 2'd3) begin
                        state  <= DONE_ST;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module optical_flow_pyramidal_top #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [7:0]        pixel_curr,
    input  logic [7:0]        pixel_prev,
    input  logic              pixel_valid,
    output logic signed [8:0] flow_u,
    output logic signed [8:0] flow_v,
    output logic              flow_valid
);
    localparam int unsigned L1_W = IMAGE_WIDTH / 2;
    localparam int unsigned L2_W = IMAGE_WIDTH / 4;
    localparam int unsigned XW   = $clog2(IMAGE_WIDTH);
    localparam int unsigned YW   = $clog2(IMAGE_HEIGHT);

    logic w_start_go;
    logic w_accept;

    optical_flow_pyramidal_fsm #(
        .TOTAL_BEATS(IMAGE_WIDTH * IMAGE_HEIGHT)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_valid    (pixel_valid),
        .o_busy     (busy),
        .o_done     (done),
        .o_start_go (w_start_go),
        .o_accept   (w_accept)
    );

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_s0_v;
    logic [7:0]    r_s0_c, r_s0_p;
    logic [XW-1:0] r_s0_x;
    logic [YW-1:0] r_s0_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_s0_v <= 1'b0;
            r_s0_c <= '0;
            r_s0_p <= '0;
            r_s0_x <= '0;
            r_s0_y <= '0;
        end else begin
            r_s0_v <= w_accept;
            if (w_start_go) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_accept) begin
                r_s0_c <= pixel_curr;
                r_s0_p <= pixel_prev;
                r_s0_x <= r_x;
                r_s0_y <= r_y;
                if (r_x == XW'(IMAGE_WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // L1 stage: even columns park the left pixel, odd columns form a horizontal pair sum
    // which even rows store and odd rows combine with the stored sum into one L1 pixel.
    logic [7:0]    r_h0_c, r_h0_p;
    logic [8:0]    r_lb1_c [L1_W];
    logic [8:0]    r_lb1_p [L1_W];
    logic          r_s1_v;
    logic [7:0]    r_s1_c, r_s1_p;
    logic [XW-2:0] r_s1_x;
    logic [YW-2:0] r_s1_y;
    logic [XW-2:0] w_x1;
    logic [8:0]    w_hs0_c, w_hs0_p;
    logic [9:0]    w_sum1_c, w_sum1_p;

    assign w_x1     = r_s0_x[XW-1:1];
    assign w_hs0_c  = {1'b0, r_h0_c} + {1'b0, r_s0_c};
    assign w_hs0_p  = {1'b0, r_h0_p} + {1'b0, r_s0_p};
    assign w_sum1_c = {1'b0, r_lb1_c[w_x1]} + {1'b0, w_hs0_c} + 10'd2;
    assign w_sum1_p = {1'b0, r_lb1_p[w_x1]} + {1'b0, w_hs0_p} + 10'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h0_c <= '0;
            r_h0_p <= '0;
            for (int unsigned i = 0; i < L1_W; i++) begin
                r_lb1_c[i] <= '0;
                r_lb1_p[i] <= '0;
            end
            r_s1_v <= 1'b0;
            r_s1_c <= '0;
            r_s1_p <= '0;
            r_s1_x <= '0;
            r_s1_y <= '0;
        end else begin
            r_s1_v <= r_s0_v && r_s0_x[0] && r_s0_y[0];
            if (r_s0_v) begin
                if (!r_s0_x[0]) begin
                    r_h0_c <= r_s0_c;
                    r_h0_p <= r_s0_p;
                end else if (!r_s0_y[0]) begin
                    r_lb1_c[w_x1] <= w_hs0_c;
                    r_lb1_p[w_x1] <= w_hs0_p;
                end else begin
                    r_s1_c <= w_sum1_c[9:2];
                    r_s1_p <= w_sum1_p[9:2];
                    r_s1_x <= w_x1;
                    r_s1_y <= r_s0_y[YW-1:1];
                end
            end
        end
    end

    logic [7:0]    r_h1_c, r_h1_p;
    logic [8:0]    r_lb2_c [L2_W];
    logic [8:0]    r_lb2_p [L2_W];
    logic          r_s2_v;
    logic [7:0]    r_s2_c, r_s2_p;
    logic [XW-3:0] r_s2_x;
    logic [YW-3:0] r_s2_y;
    logic [XW-3:0] w_x2;
    logic [8:0]    w_hs1_c, w_hs1_p;
    logic [9:0]    w_sum2_c, w_sum2_p;

    assign w_x2     = r_s1_x[XW-2:1];
    assign w_hs1_c  = {1'b0, r_h1_c} + {1'b0, r_s1_c};
    assign w_hs1_p  = {1'b0, r_h1_p} + {1'b0, r_s1_p};
    assign w_sum2_c = {1'b0, r_lb2_c[w_x2]} + {1'b0, w_hs1_c} + 10'd2;
    assign w_sum2_p = {1'b0, r_lb2_p[w_x2]} + {1'b0, w_hs1_p} + 10'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1_c <= '0;
            r_h1_p <= '0;
            for (int unsigned i = 0; i < L2_W; i++) begin
                r_lb2_c[i] <= '0;
                r_lb2_p[i] <= '0;
            end
            r_s2_v <= 1'b0;
            r_s2_c <= '0;
            r_s2_p <= '0;
            r_s2_x <= '0;
            r_s2_y <= '0;
        end else begin
            r_s2_v <= r_s1_v && r_s1_x[0] && r_s1_y[0];
            if (r_s1_v) begin
                if (!r_s1_x[0]) begin
                    r_h1_c <= r_s1_c;
                    r_h1_p <= r_s1_p;
                end else if (!r_s1_y[0]) begin
                    r_lb2_c[w_x2] <= w_hs1_c;
                    r_lb2_p[w_x2] <= w_hs1_p;
                end else begin
                    r_s2_c <= w_sum2_c[9:2];
                    r_s2_p <= w_sum2_p[9:2];
                    r_s2_x <= w_x2;
                    r_s2_y <= r_s1_y[YW-2:1];
                end
            end
        end
    end

    // Gradient stage keeps the left L2 neighbour and the previous L2 row of the current frame.
    logic [7:0]        r_left_c;
    logic [7:0]        r_row_c [L2_W];
    logic signed [8:0] w_ix, w_iy, w_it, w_neg_it;
    logic [8:0]        w_aix, w_aiy;
    logic signed [8:0] w_u_raw, w_v_raw;

    function automatic logic signed [8:0] f_limit(input logic signed [8:0] v);
`ifdef OF_PYR_SATURATE_EN
        if (v > 9'sd127)
            return 9'sd127;
        else if (v < -9'sd127)
            return -9'sd127;
        else
            return v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        w_ix     = '0;
        w_iy     = '0;
        w_it     = $signed({1'b0, r_s2_c}) - $signed({1'b0, r_s2_p});
        w_neg_it = -w_it;
        if (r_s2_x != '0)
            w_ix = $signed({1'b0, r_s2_c}) - $signed({1'b0, r_left_c});
        if (r_s2_y != '0)
            w_iy = $signed({1'b0, r_s2_c}) - $signed({1'b0, r_row_c[r_s2_x]});
        w_aix   = w_ix[8] ? 9'(-w_ix) : 9'(w_ix);
        w_aiy   = w_iy[8] ? 9'(-w_iy) : 9'(w_iy);
        w_u_raw = '0;
        w_v_raw = '0;
        if ((w_aix >= w_aiy) && (w_ix != '0))
            w_u_raw = w_ix[8] ? w_it : w_neg_it;
        if (w_aiy > w_aix)
            w_v_raw = w_iy[8] ? w_it : w_neg_it;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_c <= '0;
            for (int unsigned i = 0; i < L2_W; i++)
                r_row_c[i] <= '0;
            flow_u     <= '0;
            flow_v     <= '0;
            flow_valid <= 1'b0;
        end else begin
            flow_valid <= r_s2_v;
            if (r_s2_v) begin
                r_left_c         <= r_s2_c;
                r_row_c[r_s2_x]  <= r_s2_c;
                flow_u           <= f_limit(w_u_raw);
                flow_v           <= f_limit(w_v_raw);
            end
        end
    end
endmodule

// File: tb/tb_optical_flow_pyramidal_top.sv
// Directed bench for optical_flow_pyramidal_top on a reduced 16x12 image.
module tb_optical_flow_pyramidal_top;
    localparam int W   = 16;
    localparam int H   = 12;
    localparam int NL2 = (W / 4) * (H / 4);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, flow_valid;
    logic              pixel_valid = 1'b0;
    logic [7:0]        pixel_curr = '0;
    logic [7:0]        pixel_prev = '0;
    logic signed [8:0] flow_u, flow_v;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fv_cyc_q[$];
    int fv_u_q[$];
    int fv_v_q[$];
    int blk_q[$];

    optical_flow_pyramidal_top #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pixel_curr (pixel_curr),
        .pixel_prev (pixel_prev),
        .pixel_valid(pixel_valid),
        .flow_u     (flow_u),
        .flow_v     (flow_v),
        .flow_valid (flow_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flow_valid === 1'b1) begin
            fv_cyc_q.push_back(cyc);
            fv_u_q.push_back(int'(flow_u));
            fv_v_q.push_back(int'(flow_v));
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void gen_pix(input int pat, input int x, input int y,
                                    output logic [7:0] c, output logic [7:0] p);
        case (pat)
            1:       begin c = 8'(x / 2); p = 8'(x / 2 + 4); end
            2:       begin c = 8'(y / 2); p = 8'(y / 2 + 4); end
            3:       begin c = ((x / 4) % 2 == 1) ? 8'd200 : 8'd0; p = 8'd0; end
            default: begin c = 8'($urandom_range(255)); p = c; end
        endcase
    endfunction

    function automatic void exp_flow(input int pat, input int x2, input int y2, output int eu, output int ev);
        eu = 0;
        ev = 0;
        case (pat)
            1: eu = (x2 == 0) ? 0 : 4;
            2: ev = (y2 == 0) ? 0 : 4;
`ifdef OF_PYR_SATURATE_EN
            3: eu = (x2 % 2 == 1) ? -127 : 0;
`else
            3: eu = (x2 % 2 == 1) ? -200 : 0;
`endif
            default: ;
        endcase
    endfunction

    task automatic do_start(input string tag);
        fv_cyc_q.delete();
        fv_u_q.delete();
        fv_v_q.delete();
        blk_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_done_after_start"}, done, 0);
        check({tag, "_state_build"}, dut.u_fsm.state, 1);
    endtask

    // Drives one frame; gap_pct inserts idle cycles (optionally with stray start pulses).
    task automatic drive_frame(input int pat, input int gap_pct, input bit extra_start, input int abort_at);
        logic [7:0] c, p;
        int beat = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (beat == abort_at)
                    return;
                for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                    @(negedge clk);
                    pixel_valid = 1'b0;
                    start       = extra_start && ($urandom_range(1) == 0);
                end
                @(negedge clk);
                start = 1'b0;
                gen_pix(pat, x, y, c, p);
                pixel_curr  = c;
                pixel_prev  = p;
                pixel_valid = 1'b1;
                if (x % 4 == 3 && y % 4 == 3)
                    blk_q.push_back(cyc + 1);
                beat++;
            end
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic check_done_seq(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_flush_state"}, dut.u_fsm.state, 2);
        check({tag, "_done_low_in_flush"}, done, 0);
        @(negedge clk);
        check({tag, "_done_rise"}, done, 1);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_state_done"}, dut.u_fsm.state, 3);
    endtask

    task automatic check_frame(input string tag, input int pat);
        int eu, ev;
        check({tag, "_strobe_count"}, fv_u_q.size(), NL2);
        for (int i = 0; i < NL2 && i < fv_u_q.size() && i < blk_q.size(); i++) begin
            exp_flow(pat, i % (W / 4), i / (W / 4), eu, ev);
            check($sformatf("%s_u[%0d]", tag, i), fv_u_q[i], eu);
            check($sformatf("%s_v[%0d]", tag, i), fv_v_q[i], ev);
            check($sformatf("%s_lat[%0d]", tag, i), fv_cyc_q[i] - blk_q[i], 3);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flow_valid", flow_valid, 0);
        check("rst_flow_u", flow_u, 0);
        check("rst_flow_v", flow_v, 0);
        check("rst_state", dut.u_fsm.state, 0);
        rst_n = 1'b1;

        do_start("rand");
        drive_frame(0, 0, 1'b0, -1);
        check_done_seq("rand");
        repeat (20) @(negedge clk);
        check("rand_state_hold", dut.u_fsm.state, 3);
        check("rand_done_hold", done, 1);
        check_frame("rand", 0);

        do_start("rampx");
        drive_frame(1, 0, 1'b0, -1);
        check_done_seq("rampx");
        check_frame("rampx", 1);

        do_start("rampy");
        drive_frame(2, 0, 1'b0, -1);
        check_done_seq("rampy");
        check_frame("rampy", 2);

        do_start("alt");
        drive_frame(3, 0, 1'b0, -1);
        check_done_seq("alt");
        check_frame("alt", 3);

        do_start("gaps");
        drive_frame(0, 50, 1'b1, -1);
        check_done_seq("gaps");
        check_frame("gaps", 0);

        do_start("abort");
        drive_frame(1, 0, 1'b0, 100);
        @(negedge clk);
        pixel_valid = 1'b0;
        check("abort_pre_flow_u", flow_u, 4);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flow_valid", flow_valid, 0);
        check("abort_flow_u", flow_u, 0);
        check("abort_flow_v", flow_v, 0);
        check("abort_state", dut.u_fsm.state, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pixel_valid = 1'b1;
        repeat (5) @(negedge clk);
        pixel_valid = 1'b0;
        check("post_rst_state_idle", dut.u_fsm.state, 0);
        check("post_rst_busy", busy, 0);

        do_start("rerun");
        drive_frame(1, 0, 1'b0, -1);
        check_done_seq("rerun");
        check_frame("rerun", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
